// File: rtl/logic_op_pkg.sv
// logic_op_pkg: opcodes and FSM state encoding shared by the serial logic unit and its benches
package logic_op_pkg;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/bit_logic_cell.sv
// bit_logic_cell: combinational 1-bit AND/OR/XOR/NAND selected by op
// Ports: op (opcode), a/b (operand bits), y (result bit)
module bit_logic_cell
    import logic_op_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    always_comb begin
        y = (op == OP_AND) ? (a & b) :
            (op == OP_OR)  ? (a | b) :
            (op == OP_XOR) ? (a ^ b) : ~(a & b);
    end
endmodule

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial bitwise gate, one result bit per clock LSB first, done pulse with full word
// Ports: clk, reset_n (async active-low), start/op/in1/in2 (request, captured in IDLE),
//        busy (RUN or DONE), done (one-cycle result-valid pulse), out (held result word)
module serial_logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, shr_q, shr_d, out_q, out_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_y;

    bit_logic_cell u_cell (
        .op(op_q),
        .a (sha_q[0]),
        .b (shb_q[0]),
        .y (bit_y)
    );

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shr_d   = shr_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                sha_d   = in1;
                shb_d   = in2;
                op_d    = op;
                cnt_d   = '0;
                shr_d   = '0;
            end
            RUN: begin
                sha_d = sha_q >> 1;
                shb_d = shb_q >> 1;
                shr_d = {bit_y, shr_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                // last bit lands here; publish the completed word directly
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    out_d   = shr_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            shr_q   <= '0;
            op_q    <= OP_AND;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shr_q   <= shr_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign out  = out_q;
endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: directed self-checking bench for serial_logic_unit
module tb_serial_logic_unit;
    import logic_op_pkg::*;
    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [1:0]  op;
    logic [31:0] in1, in2, gold;
    logic        busy, done;
    logic [31:0] out;
    int          total = 0, bad = 0;

    serial_logic_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .in1(in1), .in2(in2), .busy(busy), .done(done), .out(out)
    );

    for (genvar i = 0; i < 32; i++) begin : g_gold
        bit_logic_cell u_gold (.op(op), .a(in1[i]), .b(in2[i]), .y(gold[i]));
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input string tag);
        int n;
        @(negedge clk);
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 32);
        check({tag, "_out"}, out, e);
        @(negedge clk);
        check({tag, "_idle_after"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int n, last, dones;
        logic stable, seen;
        logic [31:0] prev;
        reset_n = 1'b0; start = 1'b0; op = OP_AND; in1 = '0; in2 = '0;
        #12;
        check("reset_state", {busy, done, out}, 34'd0);
        @(negedge clk) reset_n = 1'b1;

        run_op(OP_AND,  32'h0000A5A5, 32'h00005A5A, 32'h00000000, "and_basic");
        run_op(OP_AND,  32'h00005A5A, 32'h00005A5A, 32'h00005A5A, "and_ident");
        run_op(OP_OR,   32'h0000A5A5, 32'h00005A5A, 32'h0000FFFF, "or");
        run_op(OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, "xor");
        run_op(OP_NAND, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, "nand_msb");
        run_op(OP_NAND, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, "nand_zero");

        // isolation: operands/op churn and start re-pulsed throughout RUN
        @(negedge clk);
        op = OP_XOR; in1 = 32'h12345678; in2 = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        check("iso_busy", busy, 1);
        prev = out; stable = 1'b1; n = 0;
        while (!done && n < 40) begin
            in1 = $urandom; in2 = $urandom; op = 2'($urandom); start = 1'b1;
            @(negedge clk);
            n++;
            if (!done && out !== prev) stable = 1'b0;
        end
        start = 1'b0;
        check("iso_out_held", stable, 1);
        check("iso_latency", n, 32);
        check("iso_out", out, 32'hEDCBA987);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("iso_single_done", seen, 0);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        op = OP_XOR; in1 = 32'hFFFFFFFF; in2 = 32'h0; start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("abort_async", {busy, done, out}, 34'd0);
        @(negedge clk) reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        run_op(OP_OR, 32'hF0000001, 32'h0000000E, 32'hF000000F, "after_abort");

        // continuous start: spacing and golden-model comparison
        @(negedge clk);
        op = OP_OR; in1 = 32'h13579BDF; in2 = 32'h02468ACE; start = 1'b1;
        last = -1; dones = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (done) begin
                check("cont_out_gold", out, gold);
                if (last >= 0) check("cont_spacing", c - last, 34);
                last = c; dones++;
                in1 = $urandom; in2 = $urandom; op = 2'($urandom);
            end
        end
        start = 1'b0;
        check("cont_done_count", dones, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
- Bit-serial counterpart of the team's parallel 32-bit bitwise gate.
- Accepts two WIDTH-bit operands and an opcode with a start pulse, then computes one result bit per clock, LSB first, using shift registers.
- Presents the full word with a one-cycle done pulse.
- Used in area-constrained datapaths and as a multi-cycle reference model against the parallel gate.

Parameters:
- WIDTH, 32, operand/result width; legal values 2..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NAND; captured with operands.
- in1  input  WIDTH  operand A; captured when start is accepted.
- in2  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; out is valid and new in that cycle.
- out  output  WIDTH  result register; holds its value until the next completion.

Behaviour:
- Reset: reset_n low forces state=IDLE, busy=0, done=0, out=0, counter=0, and clears the shift registers, immediately and independent of clk.
- Reset release is synchronous to the next edge; there is no other effect.
- States and transitions:
  - IDLE -> RUN when start=1 at an edge (edge E0). At E0, in1/in2/op are latched into shA/shB/opReg, counter=0, and the result shift register shR=0.
  - RUN, each edge: bit = f(opReg, shA[0], shB[0]); shA, shB shift right by 1; shR = {bit, shR[WIDTH-1:1]}; counter++.
  - RUN -> DONE at the edge where counter reaches WIDTH-1 (edge E_WIDTH). At that edge out <= final shR (including the last bit).
  - DONE -> IDLE unconditionally at the next edge.
- Latency:
  - done is high exactly in the cycle after E_WIDTH, i.e. WIDTH cycles after start is sampled.
  - The next start can be accepted at the edge ending DONE+1 (IDLE cycle); minimum issue interval is WIDTH+2 cycles.
- busy = (state != IDLE), registered-state decoded; done = (state == DONE).
- start while busy: ignored, with no queuing and no effect on the operation in flight.
- Operand and opcode inputs are don't-care outside the accepting edge; changes during RUN must not affect the result.
- out is not updated during RUN; intermediate bits never appear on out.
- Result equals the parallel bitwise op on the captured operands, for every bit position including the MSB; NAND gives ~(A&B) over all WIDTH bits.
- Reset mid-RUN or mid-DONE aborts: no done pulse, out returns to 0.
- start held high continuously: accepted only at IDLE edges, so it produces back-to-back operations with the WIDTH+2 interval.
- X on start in IDLE is a bench error; the RTL need not tolerate it.

Decomposition:
- Package logic_op_pkg:
  - Opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Shared by this block and the parallel-gate testbench.
- One natural sub-module, bit_logic_cell: combinational 1-bit op(op, a, b) -> y. Instantiate once in the serial datapath; the bench reuses it for golden-model checks.
- Counter, shift registers and FSM stay in serial_logic_unit.

Test Plan:
- Basic AND: reset, then start with op=00, in1=32'h0000A5A5, in2=32'h00005A5A -> busy rises at E0; done exactly 32 cycles later with out=32'h00000000; busy low one cycle after done.
- Identity AND: op=00, in1=in2=32'h00005A5A -> out=32'h00005A5A. Then OR of A5A5/5A5A -> out=32'h0000FFFF. Then XOR of 32'hFFFF0000/32'h0F0F0F0F -> out=32'hF0F00F0F.
- NAND with MSB coverage: op=11, in1=32'h80000000, in2=32'hFFFFFFFF -> out=32'h7FFFFFFF; in1=in2=0 -> out=32'hFFFFFFFF.
- Input isolation and start while busy: after start, change in1/in2/op and pulse start every cycle during RUN -> result matches captured operands; exactly one done per accepted start; out holds its old value until the done cycle.
- Reset mid-operation: assert reset_n=0 asynchronously 10 cycles into RUN -> busy/done/out go to 0 without a clock edge; no done follows; a fresh op after release is correct.
- Continuous start: hold start=1 for 100 cycles -> done pulses spaced 34 cycles apart; each out matches the golden bit_logic_cell model.
